// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the iterative AES encryption blocks.
//   AES_BLOCK_W            : cipher block width in bits
//   AES_NR_128/192/256     : round counts for the three AES key sizes
//   seqState_e             : 2-bit binary encoding of the round sequencer FSM
//   isLegalNr()            : true for the round counts the sequencer supports
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ROUND = 2'd1,
    SEQ_DONE  = 2'd2
  } seqState_e;

  function automatic bit isLegalNr(input int nr);
    return (nr == AES_NR_128) || (nr == AES_NR_192) || (nr == AES_NR_256);
  endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
// Iterative AES encryption controller. Holds the 128-bit cipher state, the
// round counter and the control FSM, and drives an external combinational
// round datapath (SubBytes/ShiftRows/[MixColumns]/AddRoundKey) once per cycle
// while indexing an external round-key store. One block in flight at a time.
//
// Ports
//   clk        : clock, everything on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : plaintext block offered
//   in_ready   : sequencer can accept a block (IDLE only)
//   in_data    : plaintext, bit 0 = MSB of byte 0, column-major byte order
//   rk_idx     : round-key index requested this cycle
//   rk_data    : round key for rk_idx (same-cycle combinational)
//   dp_state   : state presented to the round datapath
//   dp_last    : final round, datapath skips MixColumns
//   dp_result  : datapath output for dp_state/rk_data
//   out_valid  : ciphertext available
//   out_ready  : downstream accepts ciphertext
//   out_data   : ciphertext (held stable while out_valid && !out_ready)
//   busy       : block being processed or waiting for handoff
// ---------------------------------------------------------------------------
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR  = 10,
  parameter int RKW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:AES_BLOCK_W-1] in_data,
  output logic [RKW-1:0]         rk_idx,
  input  logic [0:AES_BLOCK_W-1] rk_data,
  output logic [0:AES_BLOCK_W-1] dp_state,
  output logic                   dp_last,
  input  logic [0:AES_BLOCK_W-1] dp_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:AES_BLOCK_W-1] out_data,
  output logic                   busy
);

  // Elaboration-time parameter guards.
  generate
    if (!isLegalNr(NR)) begin : gBadNr
      $error("aes_round_sequencer: NR must be 10, 12 or 14");
    end
    if ((2 ** RKW) <= NR) begin : gBadRkw
      $error("aes_round_sequencer: RKW too narrow to index round NR");
    end
  endgenerate

  localparam logic [RKW-1:0] LAST_ROUND = RKW'(NR);
  localparam logic [RKW-1:0] ROUND_ONE  = RKW'(1);

  seqState_e                fsmReg;
  logic [RKW-1:0]           roundReg;
  logic [0:AES_BLOCK_W-1]   blockReg;
  logic                     inReadyReg;
  logic                     outValidReg;
  logic                     busyReg;
  logic                     dpLastReg;

  // Round that will be processed next cycle while staying in ROUND.
  logic [RKW-1:0]           roundNext;
  assign roundNext = roundReg + ROUND_ONE;

  // Single FSM block: state, counter, data register and all handshake
  // outputs are updated together so every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsmReg      <= SEQ_IDLE;
      roundReg    <= '0;
      blockReg    <= '0;
      inReadyReg  <= 1'b1;
      outValidReg <= 1'b0;
      busyReg     <= 1'b0;
      dpLastReg   <= 1'b0;
    end else begin
      case (fsmReg)
        SEQ_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is the accept.
          if (in_valid) begin
            blockReg   <= in_data ^ rk_data;   // initial AddRoundKey with key 0
            roundReg   <= ROUND_ONE;
            fsmReg     <= SEQ_ROUND;
            inReadyReg <= 1'b0;
            busyReg    <= 1'b1;
            dpLastReg  <= (ROUND_ONE == LAST_ROUND);
          end
        end

        SEQ_ROUND: begin
          blockReg <= dp_result;
          if (roundReg == LAST_ROUND) begin
            // Counter returns to 0 so rk_idx reads 0 again outside ROUND.
            roundReg    <= '0;
            fsmReg      <= SEQ_DONE;
            outValidReg <= 1'b1;
            dpLastReg   <= 1'b0;
          end else begin
            roundReg  <= roundNext;
            dpLastReg <= (roundNext == LAST_ROUND);
          end
        end

        SEQ_DONE: begin
          // Leaving DONE lands in IDLE; the next accept is one cycle later.
          if (out_ready) begin
            fsmReg      <= SEQ_IDLE;
            outValidReg <= 1'b0;
            busyReg     <= 1'b0;
            inReadyReg  <= 1'b1;
          end
        end

        default: begin
          fsmReg      <= SEQ_IDLE;
          roundReg    <= '0;
          inReadyReg  <= 1'b1;
          outValidReg <= 1'b0;
          busyReg     <= 1'b0;
          dpLastReg   <= 1'b0;
        end
      endcase
    end
  end

  // roundReg is 0 outside ROUND, so it doubles as the key index everywhere.
  assign rk_idx    = roundReg;
  assign dp_state  = blockReg;
  assign dp_last   = dpLastReg;
  assign out_data  = blockReg;
  assign in_ready  = inReadyReg;
  assign out_valid = outValidReg;
  assign busy      = busyReg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
// Two sequencer instances (AES-128 and AES-256) each wired to a behavioural
// round datapath and key schedule; ciphertexts are compared with FIPS-197
// vectors and with a plain AES encryption model.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstN     [2];
  logic         inValid  [2];
  logic         inReady  [2];
  logic [127:0] inData   [2];
  logic [3:0]   rkIdx    [2];
  logic [127:0] rkData   [2];
  logic [127:0] dpState  [2];
  logic         dpLast   [2];
  logic [127:0] dpResult [2];
  logic         outValid [2];
  logic         outReady [2];
  logic [127:0] outData  [2];
  logic         busy     [2];
  logic [255:0] keyArr   [2];

  int checks = 0;
  int errors = 0;

  aes_round_sequencer #(.NR(10), .RKW(4)) u10 (
    .clk(clk), .rst_n(rstN[0]), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_data(inData[0]), .rk_idx(rkIdx[0]), .rk_data(rkData[0]),
    .dp_state(dpState[0]), .dp_last(dpLast[0]), .dp_result(dpResult[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
    .busy(busy[0])
  );

  aes_round_sequencer #(.NR(14), .RKW(4)) u14 (
    .clk(clk), .rst_n(rstN[1]), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_data(inData[1]), .rk_idx(rkIdx[1]), .rk_data(rkData[1]),
    .dp_state(dpState[1]), .dp_last(dpLast[1]), .dp_result(dpResult[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
    .busy(busy[1])
  );

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic hi;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse via x^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i > 0) r = gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic int nrOf(input int w);
    return (w == 0) ? 10 : 14;
  endfunction

  // Key is left-aligned in 256 bits; AES-128 uses only the top 128.
  function automatic logic [127:0] roundKey(input logic [255:0] key, input int nr, input int idx);
    logic [31:0] wd [64];
    logic [31:0] temp;
    logic [7:0]  rcon;
    int nk;
    nk = (nr == 10) ? 4 : ((nr == 12) ? 6 : 8);
    for (int i = 0; i < 64; i++) wd[i] = '0;
    for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      temp = wd[i-1];
      if (i % nk == 0) begin
        temp = subWord({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        temp = subWord(temp);
      end
      wd[i] = wd[i-nk] ^ temp;
    end
    if (idx < 0 || idx > nr) return '0;
    return {wd[4*idx], wd[4*idx+1], wd[4*idx+2], wd[4*idx+3]};
  endfunction

  function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] rk, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r + 4*c] = b[r + 4*((c + r) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
        t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ rk;
  endfunction

  function automatic logic [127:0] aesEncrypt(input logic [255:0] key, input logic [127:0] pt, input int nr);
    logic [127:0] s;
    s = pt ^ roundKey(key, nr, 0);
    for (int r = 1; r <= nr; r++) s = aesRound(s, roundKey(key, nr, r), r == nr);
    return s;
  endfunction

  // External key store and round datapath for both instances.
  always_comb begin : extDatapath
    logic [127:0] k;
    for (int w = 0; w < 2; w++) begin
      k = roundKey(keyArr[w], nrOf(w), int'(rkIdx[w]));
      rkData[w]   = k;
      dpResult[w] = aesRound(dpState[w], k, dpLast[w]);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the instance idle. Offers one block, checks the
  // round sequencing and latency, holds out_ready low for 'hold' cycles in
  // DONE, then hands off.
  task automatic runBlock(input int w, input logic [255:0] key, input logic [127:0] pt,
                          input int hold, output logic [127:0] ct);
    int nr, k;
    logic [127:0] held;
    nr = nrOf(w);
    keyArr[w] = key;
    outReady[w] = 1'b0;
    check("idle_in_ready", 128'(inReady[w]), 128'(1));
    check("idle_rk_idx", 128'(rkIdx[w]), 128'(0));
    inValid[w] = 1'b1;
    inData[w]  = pt;
    @(negedge clk);
    inValid[w] = 1'b0;
    inData[w]  = ~pt;   // must be ignored after the accept edge
    k = 1;
    while (outValid[w] !== 1'b1 && k <= 40) begin
      check("round_rk_idx", 128'(rkIdx[w]), 128'(k));
      check("round_dp_last", 128'(dpLast[w]), 128'(k == nr));
      check("round_in_ready", 128'(inReady[w]), 128'(0));
      check("round_busy", 128'(busy[w]), 128'(1));
      @(negedge clk);
      k++;
    end
    check("latency", 128'(k), 128'(nr + 1));
    held = outData[w];
    for (int h = 0; h < hold; h++) begin
      check("hold_out_valid", 128'(outValid[w]), 128'(1));
      check("hold_out_data", outData[w], held);
      check("hold_in_ready", 128'(inReady[w]), 128'(0));
      check("hold_busy", 128'(busy[w]), 128'(1));
      @(negedge clk);
    end
    outReady[w] = 1'b1;
    check("handoff_out_valid", 128'(outValid[w]), 128'(1));
    check("done_rk_idx", 128'(rkIdx[w]), 128'(0));
    @(negedge clk);
    outReady[w] = 1'b0;
    check("post_out_valid", 128'(outValid[w]), 128'(0));
    check("post_in_ready", 128'(inReady[w]), 128'(1));
    check("post_busy", 128'(busy[w]), 128'(0));
    ct = held;
    $display("block nr=%0d pt=%h ct=%h latency=%0d hold=%0d", nr, pt, ct, k, hold);
  endtask

  task automatic checkResetState(input int w);
    check("rst_in_ready", 128'(inReady[w]), 128'(1));
    check("rst_out_valid", 128'(outValid[w]), 128'(0));
    check("rst_busy", 128'(busy[w]), 128'(0));
    check("rst_rk_idx", 128'(rkIdx[w]), 128'(0));
    check("rst_dp_last", 128'(dpLast[w]), 128'(0));
    check("rst_out_data", outData[w], 128'(0));
    check("rst_dp_state", dpState[w], 128'(0));
  endtask

  typedef struct {
    int           w;
    logic [255:0] key;
    logic [127:0] pt;
    int           hold;
    logic [127:0] exp;
  } vec_t;

  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;

  vec_t vecs [10];

  initial begin
    logic [127:0] ct, ct1, pt2, ptR;
    logic [255:0] keyR;
    logic [127:0] outs [2];
    int acc [2];
    int nAcc, nOut, k;
    bit sawOut;

    for (int w = 0; w < 2; w++) begin
      rstN[w] = 1'b0; inValid[w] = 1'b0; inData[w] = '0;
      outReady[w] = 1'b0; keyArr[w] = '0;
    end

    // Vector table: FIPS-197 C.1 / C.3 plus random blocks.
    vecs[0] = '{0, KEY128, PT, 0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{0, KEY128, PT, 5, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{1, KEY256, PT, 0, 128'h8ea2b7ca516745bfeafc49904b496089};
    vecs[3] = '{1, KEY256, PT, 3, 128'h8ea2b7ca516745bfeafc49904b496089};
    for (int i = 4; i < 10; i++) begin
      vecs[i].w    = i % 2;
      vecs[i].key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (vecs[i].w == 0) vecs[i].key[127:0] = '0;
      vecs[i].pt   = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].hold = int'($urandom_range(0, 4));
      vecs[i].exp  = aesEncrypt(vecs[i].key, vecs[i].pt, nrOf(vecs[i].w));
    end

    // Reset.
    repeat (2) @(negedge clk);
    checkResetState(0);
    checkResetState(1);
    rstN[0] = 1'b1; rstN[1] = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      runBlock(vecs[i].w, vecs[i].key, vecs[i].pt, vecs[i].hold, ct);
      check($sformatf("vec%0d_ct", i), ct, vecs[i].exp);
    end

    // Back-to-back with in_valid held high and out_ready high.
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    keyArr[0] = KEY128;
    inValid[0] = 1'b1; inData[0] = PT; outReady[0] = 1'b1;
    nAcc = 0; nOut = 0; acc[0] = 0; acc[1] = 0; outs[0] = '0; outs[1] = '0;
    for (int t = 0; t < 60 && nOut < 2; t++) begin
      if (inReady[0] && inValid[0] && nAcc < 2) begin acc[nAcc] = t; nAcc++; end
      if (outValid[0] && outReady[0]) begin outs[nOut] = outData[0]; nOut++; end
      @(negedge clk);
      if (nAcc == 1) inData[0] = pt2;
      if (nAcc == 2) inValid[0] = 1'b0;
    end
    inValid[0] = 1'b0; outReady[0] = 1'b0;
    check("b2b_accepts", 128'(nAcc), 128'(2));
    check("b2b_interval", 128'(acc[1] - acc[0]), 128'(12));
    check("b2b_outputs", 128'(nOut), 128'(2));
    check("b2b_ct1", outs[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("b2b_ct2", outs[1], aesEncrypt(KEY128, pt2, 10));
    $display("back-to-back accepts at %0d and %0d ct1=%h ct2=%h", acc[0], acc[1], outs[0], outs[1]);
    @(negedge clk);

    // Reset in the middle of round 5.
    keyR = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    ptR  = {$urandom, $urandom, $urandom, $urandom};
    keyArr[0] = keyR;
    inValid[0] = 1'b1; inData[0] = ptR;
    @(negedge clk);
    inValid[0] = 1'b0;
    k = 1;
    while (rkIdx[0] != 4'd5 && k < 20) begin @(negedge clk); k++; end
    check("midrst_reached_round5", 128'(rkIdx[0]), 128'(5));
    rstN[0] = 1'b0;
    @(negedge clk);
    rstN[0] = 1'b1;
    checkResetState(0);
    sawOut = 1'b0;
    outReady[0] = 1'b1;
    for (int t = 0; t < 15; t++) begin
      if (outValid[0]) sawOut = 1'b1;
      @(negedge clk);
    end
    outReady[0] = 1'b0;
    check("midrst_no_output", 128'(sawOut), 128'(0));
    $display("reset at round 5 aborted block pt=%h", ptR);
    runBlock(0, keyR, ptR, 1, ct);
    check("midrst_next_ct", ct, aesEncrypt(keyR, ptR, 10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
